// File: rtl/decode_pkg.sv
// Shared definitions for the MIPS decode stage: opcode/funct encodings,
// the ALU control enum handed to execute, and the memory/register flag bundle.
package decode_pkg;

    // Primary opcodes (ir[31:26])
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // R-type function codes (ir[5:0])
    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_NOP = 3'd7
    } aluctr_e;

    typedef struct packed {
        logic mem_rd;
        logic mem_wr;
        logic reg_wr;
    } dx_ctrl_t;

endpackage

// File: rtl/decode_if.sv
// Bundle of the fetch, write-back, execute and redirect signals around the
// decode stage. The stage uses the slave modport; its environment the master.
interface decode_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int REG_AW = $clog2(NREG);

    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_ir;
    logic [XLEN-1:0]   if_pc;

    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;

    logic              dx_valid;
    logic              dx_ready;
    logic [XLEN-1:0]   dx_a;
    logic [XLEN-1:0]   dx_b;
    logic [XLEN-1:0]   dx_imm;
    logic [REG_AW-1:0] dx_rd;
    logic [2:0]        dx_aluctr;
    logic              dx_mem_rd;
    logic              dx_mem_wr;
    logic              dx_reg_wr;
    logic              dx_illegal;

    logic              br_taken;
    logic [XLEN-1:0]   br_target;

    modport master (
        output if_valid, if_ir, if_pc, wb_we, wb_rd, wb_data, dx_ready,
        input  if_ready, dx_valid, dx_a, dx_b, dx_imm, dx_rd, dx_aluctr,
               dx_mem_rd, dx_mem_wr, dx_reg_wr, dx_illegal, br_taken, br_target
    );

    modport slave (
        input  if_valid, if_ir, if_pc, wb_we, wb_rd, wb_data, dx_ready,
        output if_ready, dx_valid, dx_a, dx_b, dx_imm, dx_rd, dx_aluctr,
               dx_mem_rd, dx_mem_wr, dx_reg_wr, dx_illegal, br_taken, br_target
    );

endinterface

// File: rtl/decode_scoreboard.sv
// Per-register pending-write counters. Issue of a register-writing instruction
// increments, write-back decrements, both together cancel. A write-back on an
// idle register (e.g. one issued before reset) leaves the counter at zero.
// Optional: DECODE_WB_BYPASS_EN lets a count of one that is being written back
// this cycle read as not busy.
module decode_scoreboard #(
    parameter int NREG         = 32,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc_en,
    input  logic [$clog2(NREG)-1:0]  inc_rd,
    input  logic                     dec_en,
    input  logic [$clog2(NREG)-1:0]  dec_rd,
    output logic [NREG-1:0]          busy,
    output logic [NREG-1:0]          full
);
    localparam int REG_AW = $clog2(NREG);
    localparam int PW     = $clog2(MAX_INFLIGHT + 1);

    logic [PW-1:0]   cnt [NREG];
    logic [NREG-1:0] inc_hit;
    logic [NREG-1:0] dec_hit;

    // Decode which counter is touched by issue and by write-back this cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        inc_hit = '0;
        dec_hit = '0;
        for (int i = 1; i < NREG; i++) begin
            inc_hit[i] = inc_en && (inc_rd == REG_AW'(i));
            dec_hit[i] = dec_en && (dec_rd == REG_AW'(i));
        end
    end

    // Counter update; register 0 never changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this is a small flop array, not a RAM, so it is reset explicitly element by element.
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                // NOTE: sequential state is updated with non-blocking assignments only.
                if (inc_hit[i] && !dec_hit[i])
                    cnt[i] <= cnt[i] + PW'(1);
                else if (dec_hit[i] && !inc_hit[i] && cnt[i] != '0)
                    cnt[i] <= cnt[i] - PW'(1);
            end
        end
    end

    // Status flags seen by the hazard check.
    always_comb begin
        busy = '0;
        full = '0;
        for (int i = 0; i < NREG; i++) begin
            busy[i] = (cnt[i] != '0);
            full[i] = (cnt[i] == PW'(MAX_INFLIGHT));
`ifdef DECODE_WB_BYPASS_EN
            if (dec_hit[i] && cnt[i] == PW'(1)) busy[i] = 1'b0;
`endif
        end
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: register file, scoreboard interlock, beq/bne/j resolution
// and a one-entry output register toward execute with backpressure.
// Optional: DECODE_WB_BYPASS_EN forwards the write-back port into operand reads
// so a dependent instruction can issue on the write-back edge.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NREG         = 32,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic    clk,
    input  logic    rst,
    decode_if.slave bus
);
    localparam int REG_AW = $clog2(NREG);

    logic [XLEN-1:0]   rf [NREG];
    logic [5:0]        op;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd_field;
    logic [REG_AW-1:0] dest;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   redirect_target;
    logic              is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j;
    logic              is_illegal, use_rs, use_rt, issues_op, redirect;
    aluctr_e           alu;
    dx_ctrl_t          ctrl;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   full;
    logic              hazard;
    logic              fire;
    logic              squash_q;
    logic              unused_shamt;

    logic              dx_valid_q;
    logic [XLEN-1:0]   dx_a_q, dx_b_q, dx_imm_q;
    logic [REG_AW-1:0] dx_rd_q;
    aluctr_e           aluctr_q;
    dx_ctrl_t          ctrl_q;
    logic              illegal_q;
    logic              br_taken_q;
    logic [XLEN-1:0]   br_target_q;

    assign op           = bus.if_ir[31:26];
    assign funct        = bus.if_ir[5:0];
    assign rs           = REG_AW'(bus.if_ir[25:21]);
    assign rt           = REG_AW'(bus.if_ir[20:16]);
    assign rd_field     = REG_AW'(bus.if_ir[15:11]);
    assign unused_shamt = ^bus.if_ir[10:6];
    assign imm          = {{(XLEN-16){bus.if_ir[15]}}, bus.if_ir[15:0]};
    assign pc_plus4     = bus.if_pc + XLEN'(4);

    // Instruction classification and ALU control selection.
    always_comb begin
        is_r    = 1'b0;
        is_addi = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_j    = 1'b0;
        alu     = ALU_NOP;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu = ALU_ADD;
                    FN_SUB:  alu = ALU_SUB;
                    FN_AND:  alu = ALU_AND;
                    FN_OR:   alu = ALU_OR;
                    FN_SLT:  alu = ALU_SLT;
                    default: alu = ALU_NOP;
                endcase
                is_r = (alu != ALU_NOP);
            end
            OP_ADDI: begin is_addi = 1'b1; alu = ALU_ADD; end
            OP_LW:   begin is_lw   = 1'b1; alu = ALU_ADD; end
            OP_SW:   begin is_sw   = 1'b1; alu = ALU_ADD; end
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            OP_J:    is_j   = 1'b1;
            default: alu = ALU_NOP;
        endcase
    end

    // Source usage, destination and control flags derived from the class.
    always_comb begin
        issues_op   = is_r | is_addi | is_lw | is_sw;
        is_illegal  = !(issues_op | is_beq | is_bne | is_j);
        use_rs      = issues_op | is_beq | is_bne;
        use_rt      = is_r | is_sw | is_beq | is_bne;
        dest        = '0;
        if (is_r)                dest = rd_field;
        else if (is_addi | is_lw) dest = rt;
        ctrl.mem_rd = is_lw;
        ctrl.mem_wr = is_sw;
        ctrl.reg_wr = (dest != '0);
    end

    // Operand read; r0 is hardwired to zero.
    always_comb begin
        op_a = (rs == '0) ? '0 : rf[rs];
        op_b = (rt == '0) ? '0 : rf[rt];
`ifdef DECODE_WB_BYPASS_EN
        if (bus.wb_we && bus.wb_rd != '0 && bus.wb_rd == rs) op_a = bus.wb_data;
        if (bus.wb_we && bus.wb_rd != '0 && bus.wb_rd == rt) op_b = bus.wb_data;
`endif
    end

    // Branch resolution and redirect address.
    always_comb begin
        redirect = is_j | (is_beq & (op_a == op_b)) | (is_bne & (op_a != op_b));
        if (is_j)
            redirect_target = {pc_plus4[XLEN-1:28], bus.if_ir[25:0], 2'b00};
        else
            redirect_target = pc_plus4 + (imm << 2);
    end

    // Interlock and issue; a squashed beat is accepted regardless of hazards.
    always_comb begin
        hazard = (use_rs & busy[rs]) | (use_rt & busy[rt]) | (ctrl.reg_wr & full[dest]);
        fire   = bus.if_valid & ~squash_q & ~hazard & (~dx_valid_q | bus.dx_ready);
    end

    assign bus.if_ready = fire | squash_q;

    decode_scoreboard #(
        .NREG         (NREG),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_scoreboard (
        .clk    (clk),
        .rst    (rst),
        .inc_en (fire & ctrl.reg_wr),
        .inc_rd (dest),
        .dec_en (bus.wb_we),
        .dec_rd (bus.wb_rd),
        .busy   (busy),
        .full   (full)
    );

    // Register file write port; writes to r0 are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (bus.wb_we && bus.wb_rd != '0) begin
            rf[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Output register toward execute, redirect pulse and squash flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            dx_valid_q  <= 1'b0;
            dx_a_q      <= '0;
            dx_b_q      <= '0;
            dx_imm_q    <= '0;
            dx_rd_q     <= '0;
            aluctr_q    <= ALU_NOP;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            squash_q    <= 1'b0;
        end else begin
            br_taken_q <= 1'b0;
            illegal_q  <= 1'b0;
            if (fire) begin
                dx_valid_q <= issues_op;
                dx_a_q     <= op_a;
                dx_b_q     <= op_b;
                dx_imm_q   <= imm;
                dx_rd_q    <= dest;
                aluctr_q   <= alu;
                ctrl_q     <= ctrl;
                illegal_q  <= is_illegal;
                if (redirect) begin
                    br_taken_q  <= 1'b1;
                    br_target_q <= redirect_target;
                    squash_q    <= 1'b1;
                end
            end else begin
                if (bus.dx_ready) dx_valid_q <= 1'b0;
                if (squash_q && bus.if_valid) squash_q <= 1'b0;
            end
        end
    end

    assign bus.dx_valid   = dx_valid_q;
    assign bus.dx_a       = dx_a_q;
    assign bus.dx_b       = dx_b_q;
    assign bus.dx_imm     = dx_imm_q;
    assign bus.dx_rd      = dx_rd_q;
    assign bus.dx_aluctr  = aluctr_q;
    assign bus.dx_mem_rd  = ctrl_q.mem_rd;
    assign bus.dx_mem_wr  = ctrl_q.mem_wr;
    assign bus.dx_reg_wr  = ctrl_q.reg_wr;
    assign bus.dx_illegal = illegal_q;
    assign bus.br_taken   = br_taken_q;
    assign bus.br_target  = br_target_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised instruction-decode stage for the 5-stage MIPS pipeline, sitting between fetch and execute. It holds the register file and a per-register pending-write scoreboard for RAW/WAW interlocking, and resolves beq/bne/j in decode. Fetch and execute connect through valid/ready handshakes, and execute-side backpressure is honoured. Write-back enters through a dedicated write port.

## Interface
- XLEN, 32, datapath width (≥32)
- NREG, 32, architectural register count (power of 2; `REG_AW = log2(NREG)`)
- MAX_INFLIGHT, 3, maximum outstanding writes per register (counter width `PW = clog2(MAX_INFLIGHT+1)`)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- if_valid / if_ready  in/out  1  fetch handshake
- if_ir  in  32  instruction word
- if_pc  in  XLEN  address of `if_ir`
- wb_we  in  1  write-back enable
- wb_rd  in  REG_AW  write-back register
- wb_data  in  XLEN  write-back data
- dx_valid / dx_ready  out/in  1  execute handshake
- dx_a, dx_b, dx_imm  out  XLEN  operand rs, operand rt, sign-extended imm16
- dx_rd  out  REG_AW  destination register
- dx_aluctr  out  3  0 add, 1 sub, 2 and, 3 or, 4 slt, 7 nop
- dx_mem_rd, dx_mem_wr, dx_reg_wr  out  1  lw / sw / register-writing flags
- br_taken  out  1  one-cycle redirect pulse
- br_target  out  XLEN  redirect address
- dx_illegal  out  1  one-cycle pulse for an unsupported opcode/funct

## Operation
- **Supported instructions**
  - R-type (op 0): add 32, sub 34, and 36, or 37, slt 42.
  - addi 8, lw 35, sw 43, beq 4, bne 5, j 2.
- **Reads and writes**
  - Source `rs = ir[25:21]`, `rt = ir[20:16]`.
  - rt counts as a read only for R-type, sw, beq and bne.
  - Register 0 always reads 0.
  - A write with `wb_rd == 0` is ignored.
- **Destination**
  - R-type: `dx_rd = ir[15:11]`; addi/lw: `dx_rd = ir[20:16]`.
  - `dx_reg_wr` is set only when the destination is nonzero.
- **Scoreboard**
  - One PW-bit counter per register.
  - Increment on issue of a register-writing instruction to that register.
  - Decrement on `wb_we` to that register.
  - Simultaneous increment and decrement leave the counter unchanged.
  - Decrement at 0 stays 0 (for example, write-backs from before a reset).
- **Hazard (holds the instruction)** — any of:
  - a used source counter is nonzero;
  - the destination counter equals MAX_INFLIGHT.
- **Issue (fire)**
  - Condition: `if_valid & !hazard & (!dx_valid | dx_ready)`.
  - `if_ready = fire | squash_q`.
- **Output register**
  - Loads on fire.
  - Holds while `dx_valid & !dx_ready`.
  - `dx_valid` clears when execute consumes the entry and no new instruction is issued.
- **Branches**
  - beq/bne compare the operands read in decode. Target = `pc+4 + (sext(imm16)<<2)`.
  - j target = `{pc_plus4[XLEN-1:28], ir[25:0], 2'b00}`.
  - Branches and jumps issue as bubbles: `dx_valid = 0` and `dx_aluctr = 7`.
  - A taken branch or a jump pulses `br_taken` and sets `squash_q`.
  - A not-taken branch produces no pulse.
- **Squash**
  - While `squash_q` is set, the next `if_valid` beat is accepted and dropped, then `squash_q` clears.
  - A hazard never blocks a squashed beat.
- **Illegal opcode**: accepted, issued as a bubble, `dx_illegal` pulses for one cycle, scoreboard untouched.

## Timing
- Decode latency is one cycle: fire at edge N gives `dx_*` and `br_*` valid after edge N.
- `br_taken` is high for exactly one cycle per redirect, so the branch penalty is one bubble.
- Write-back at edge N updates the register array and decrements the counter at that same edge.
  - Without bypass, a dependent instruction issues at edge N+1 at the earliest.
- lw to a dependent ALU instruction stalls until the lw write-back, through the scoreboard only (no execute forwarding).
- Values on reset:
  - `dx_valid`, `br_taken` and `dx_illegal` are 0.
  - All `dx_*` data and control outputs are 0, except `dx_aluctr = 7`.
  - `br_target` is 0.
  - All counters and `squash_q` are 0.
  - All registers are 0.
- Reset mid-stall drops the held instruction. Fetch re-presents it after its own reset.

## Configuration
- `DECODE_WB_BYPASS_EN` defined:
  - A source equal to a nonzero `wb_rd` with `wb_we` set reads `wb_data` in the same cycle.
  - A counter value of 1 that is matched by that write-back is treated as clear, so a dependent instruction issues at edge N.
- Not defined:
  - Reads come from the array only.
  - The stall releases one cycle later (edge N+1).

## Structure
- Shared package `decode_pkg` holds:
  - opcode and funct constants;
  - the ALUctr enum (ADD, SUB, AND, OR, SLT, NOP=7);
  - a `dx_ctrl_t` struct for the mem/reg flags.
- Sub-module `decode_scoreboard` holds the NREG×PW counters and the increment/decrement logic. Its outputs are `busy[NREG]` and `full[NREG]`.

## Test plan
- add r3,r1,r2 with r1=5, r2=7, then write-back of r3 → dx_a=5, dx_b=7, dx_aluctr=0; a following sub r4,r3,r1 holds until r3's write-back (released at edge N+1 without bypass, at edge N with bypass) and reads r3=12.
- lw r2,4(r1) followed by slt r5,r2,r0 → slt held (`if_ready=0`) until `wb_we` on r2; `dx_mem_rd=1`, `dx_imm=4`.
- beq r1,r1,-2 at pc=0x40 → `br_taken` pulses once with `br_target=0x3C`, the next fetch beat is dropped, and `dx_valid` stays 0; bne with equal operands → no pulse.
- dx_ready held 0 for 3 cycles while if_valid=1 → dx_* outputs stable and no issue; the instruction issues on the cycle dx_ready rises.
- Four writes to r7 issued with no write-back → the fourth is held (counter = 3); one write-back to r7 releases it; write-back with wb_rd=0 leaves r0 reading 0.
- rst asserted mid-stall → the next cycle shows dx_valid=0, dx_aluctr=7, all counters 0, and r1 reads 0.
